// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
// Holds the loader state encoding and the default frame/timeout constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    localparam logic [7:0]  DEF_SYNC_BYTE   = 8'hA5;
    localparam int unsigned DEF_TIMEOUT_CYC = 1_000_000;

endpackage

// File: rtl/loader_timeout_ctr.sv
// Inter-byte idle timeout: reloads on clr, counts down while enabled,
// and flags expiry TIMEOUT_CYC enabled cycles after the last clear.
module loader_timeout_ctr
    import imem_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned   CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= LOAD;
        end else if (clr) begin
            cnt <= LOAD;
        end else if (en && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Reload value is one short so expiry lands on the TIMEOUT_CYC-th idle edge.
    assign expire = en && !clr && (cnt == '0);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: assembles little-endian words, writes them to
// instruction memory, verifies the XOR checksum and gates the core reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int unsigned WIDX_W = $clog2(DEPTH_WORDS + 1);

    loader_state_t     state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       len_q, len_d;
    logic [WIDX_W-1:0] word_q, word_d;
    logic [1:0]        byte_q, byte_d;
    logic [23:0]       asm_q, asm_d;
    logic [7:0]        acc_q, acc_d;
    logic              we_d, hold_d, done_d, error_d;
    logic [31:0]       waddr_d, wdata_d;

    logic accept, tmo_active, tmo_expire;
    logic [15:0] len_in;

    assign accept     = in_valid && in_ready;
    assign len_in     = {in_data, len_lo_q};
    assign tmo_active = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                        (state_q == ST_DATA) || (state_q == ST_CHECK);

    loader_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept || !tmo_active),
        .en     (tmo_active),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            len_lo_q   <= '0;
            len_q      <= '0;
            word_q     <= '0;
            byte_q     <= '0;
            asm_q      <= '0;
            acc_q      <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= BASE_ADDR;
            imem_wdata <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            word_q     <= word_d;
            byte_q     <= byte_d;
            asm_q      <= asm_d;
            acc_q      <= acc_d;
            in_ready   <= 1'b1;
            imem_we    <= we_d;
            imem_waddr <= waddr_d;
            imem_wdata <= wdata_d;
            cpu_hold   <= hold_d;
            done       <= done_d;
            error      <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        word_d   = word_q;
        byte_d   = byte_q;
        asm_d    = asm_q;
        acc_d    = acc_q;
        we_d     = 1'b0;
        waddr_d  = imem_waddr;
        wdata_d  = imem_wdata;
        hold_d   = cpu_hold;
        done_d   = done;
        error_d  = error;

        case (state_q)
            ST_IDLE: begin
                if (accept && in_data == SYNC_BYTE) state_d = ST_LEN0;
            end
            ST_LEN0: begin
                if (accept) begin
                    len_lo_d = in_data;
                    state_d  = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (accept) begin
                    len_d  = len_in;
                    word_d = '0;
                    byte_d = '0;
                    acc_d  = '0;
                    if (32'(len_in) > DEPTH_WORDS) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end else if (len_in == '0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    acc_d  = acc_q ^ in_data;
                    byte_d = byte_q + 2'd1;
                    case (byte_q)
                        2'd0: asm_d[7:0]   = in_data;
                        2'd1: asm_d[15:8]  = in_data;
                        2'd2: asm_d[23:16] = in_data;
                        default: begin
                            we_d    = 1'b1;
                            waddr_d = BASE_ADDR + (32'(word_q) << 2);
                            wdata_d = {in_data, asm_q};
                            word_d  = word_q + WIDX_W'(1);
                            if (32'(word_q) + 32'd1 == 32'(len_q)) state_d = ST_CHECK;
                        end
                    endcase
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    if (in_data == acc_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                if (accept && in_data == SYNC_BYTE) begin
                    state_d = ST_LEN0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    hold_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Expiry never coincides with an accepted byte, so it cannot clobber a write.
        if (tmo_expire) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
            hold_d  = 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: nominal load, checksum and
// length errors, idle timeout, noise rejection and mid-frame reset.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned we_cnt = 0;
    int unsigned base;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];

    always #5 clk = ~clk;

    imem_loader #(
        .DEPTH_WORDS (256),
        .BASE_ADDR   (32'h0000_0000),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    // Write monitor: each cycle imem_we is high counts as one pulse.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (we_cnt < 16) begin
                wr_addr[we_cnt] = imem_waddr;
                wr_data[we_cnt] = imem_wdata;
            end
            we_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Presents a byte at the negedge; returns 1 time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_load(input logic [7:0] chk);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h01); send_byte(8'h20); send_byte(8'h00);
        send_byte(chk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_waddr", imem_waddr, 32'h0);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_hold", cpu_hold, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", in_ready, 1);

        // Nominal load; XOR of payload 93^00^10^00^13^01^20^00 = B1
        base = we_cnt;
        send_load(8'hB1);
        check("nom_we_cnt", we_cnt - base, 2);
        check("nom_addr0", wr_addr[base], 32'h0);
        check("nom_data0", wr_data[base], 32'h0010_0093);
        check("nom_addr1", wr_addr[base+1], 32'h4);
        check("nom_data1", wr_data[base+1], 32'h0020_0113);
        check("nom_done", done, 1);
        check("nom_hold", cpu_hold, 0);
        check("nom_error", error, 0);
        check("nom_waddr_held", imem_waddr, 32'h4);

        // Bad checksum, restarting from DONE
        base = we_cnt;
        send_byte(8'hA5);
        check("restart_done", done, 0);
        check("restart_hold", cpu_hold, 1);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h01); send_byte(8'h20); send_byte(8'h00);
        send_byte(8'h00);
        check("badchk_we_cnt", we_cnt - base, 2);
        check("badchk_error", error, 1);
        check("badchk_done", done, 0);
        check("badchk_hold", cpu_hold, 1);

        // Zero length, good and bad checksum
        base = we_cnt;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("zero_done", done, 1);
        check("zero_error", error, 0);
        check("zero_we_cnt", we_cnt - base, 0);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        check("zero_bad_error", error, 1);
        check("zero_bad_done", done, 0);

        // Oversize length 0x0101 > 256
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("pre_over_done", done, 1);
        base = we_cnt;
        send_byte(8'hA5); send_byte(8'h01);
        check("over_len_lo_error", error, 0);
        send_byte(8'h01);
        check("over_error", error, 1);
        check("over_hold", cpu_hold, 1);
        send_load(8'hB1);
        check("over_follow_done", done, 1);
        check("over_follow_we_cnt", we_cnt - base, 2);
        check("over_follow_data1", wr_data[base+1], 32'h0020_0113);

        // Timeout after two payload bytes
        base = we_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        repeat (99) @(posedge clk);
        #1;
        check("tmo_error_at_99", error, 0);
        @(posedge clk);
        #1;
        check("tmo_error_at_100", error, 1);
        check("tmo_hold", cpu_hold, 1);
        check("tmo_we_cnt", we_cnt - base, 0);

        // Noise in IDLE, then reset mid-DATA
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_byte(8'h00); send_byte(8'hFF);
        check("noise_done", done, 0);
        check("noise_error", error, 0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_we", imem_we, 0);
        check("midrst_waddr", imem_waddr, 32'h0);
        check("midrst_wdata", imem_wdata, 32'h0);
        check("midrst_hold", cpu_hold, 1);
        check("midrst_done", done, 0);
        check("midrst_error", error, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        base = we_cnt;
        send_byte(8'h00); send_byte(8'hFF);
        send_load(8'hB1);
        check("post_rst_we_cnt", we_cnt - base, 2);
        check("post_rst_addr0", wr_addr[base], 32'h0);
        check("post_rst_data0", wr_data[base], 32'h0010_0093);
        check("post_rst_data1", wr_data[base+1], 32'h0020_0113);
        check("post_rst_done", done, 1);
        check("post_rst_hold", cpu_hold, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
